alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Iterative RV32M multiply/divide unit with parametrised datapath width.
- Sits beside the single-cycle ALU in the execute stage and shares its I_data1/I_data2 operand convention.
- Adds multi-cycle operation, a start/valid handshake, signed/unsigned high-half products, and RISC-V division corner cases.
- The pipeline stalls on O_ready=0 and writes back on O_valid.

Parameters:
- XLEN, 32, operand/result width in bits; must be even and >=8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- I_clk  in  1  rising-edge clock
- I_rst  in  1  synchronous, active-high reset
- I_start  in  1  request; accepted on an edge where I_start=1, O_ready=1, I_flush=0
- I_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- I_data1  in  XLEN  rs1 (multiplicand / dividend)
- I_data2  in  XLEN  rs2 (multiplier / divisor)
- I_flush  in  1  abandon the current operation (pipeline squash)
- O_ready  out  1  high only in IDLE
- O_valid  out  1  one-cycle result strobe
- O_data  out  XLEN  result; holds its value until the next result is written

Behaviour:
- One clock domain only. Reset is synchronous and active-high.
- Reset: I_rst=1 at an edge sets state=IDLE, O_ready=1, O_valid=0, O_data=0, counter=0. This applies mid-operation too; the in-flight result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - On accept, latch the op, operand signs and operand magnitudes, then go to CALC with counter=0.
  - Signedness: both operands signed for MULH, DIV, REM; rs1 only for MULHSU; neither for MULHU, DIVU, REMU. MUL is sign-agnostic (low word).
- Fast path at accept, goes straight to DONE:
  - DIV/DIVU with divisor 0: result all-ones.
  - REM/REMU with divisor 0: result = I_data1.
  - DIV with I_data1 = 1<<(XLEN-1) and I_data2 = all-ones: result = I_data1.
  - REM with the same operands: result 0.
- CALC: one radix-2 step per edge, XLEN steps total. Counter reaches XLEN-1 on the last step, then state goes to DONE.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring, using an XLEN+1-bit partial remainder.
- Final sign fix-up, done in the DONE-entry edge:
  - MUL*: negate the 2*XLEN product if the operand signs differ.
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the dividend's sign.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DONE:
  - O_valid=1 and O_data updated for exactly one cycle; O_ready=0.
  - Next edge goes to IDLE unconditionally.
  - I_start is not accepted in DONE.
- Latency, with the accept edge as edge 0:
  - Normal ops: O_valid high in the cycle after edge XLEN, i.e. XLEN cycles after accept.
  - Fast path: O_valid high in the cycle after edge 0.
  - Throughput: one op per XLEN+2 cycles.
- I_start while O_ready=0 is ignored; no queuing.
- I_flush:
  - In CALC or DONE: next edge goes to IDLE, O_valid=0, O_data unchanged.
  - In IDLE: flush blocks acceptance (flush beats start).
  - I_rst beats I_flush.
- O_valid is never high in two consecutive cycles.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), XLEN=32 -> O_data=0xFFFFFFEB. O_valid high exactly 32 cycles after the accept edge, for one cycle; O_ready low throughout.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MUL 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. REMU 0xFFFFFFF9/2 -> 0x00000001. REM 7/−2 -> 0x00000001.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each with O_valid one cycle after accept.
- Issue DIV 100/3, assert I_flush at cycle 10 -> no O_valid, O_ready=1 next cycle, O_data keeps its prior value. Issue again and pulse I_start at cycles 5 and 20 -> ignored, single result 33. Then I_start+I_flush together in IDLE -> no accept.
- I_rst during cycle 15 of a MULHU -> next cycle O_ready=1, O_valid=0, O_data=0. Immediately start MUL 3×4 -> 0x0000000C. Then back-to-back requests -> second accepted on the first edge with O_ready=1, XLEN+2 cycles after the first accept.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the execute stage and the iterative mul/div unit.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            I_start;
  logic [2:0]      I_op;
  logic [XLEN-1:0] I_data1;
  logic [XLEN-1:0] I_data2;
  logic            I_flush;
  logic            O_ready;
  logic            O_valid;
  logic [XLEN-1:0] O_data;

  modport master (
    output I_start, I_op, I_data1, I_data2, I_flush,
    input  O_ready, O_valid, O_data
  );

  modport slave (
    input  I_start, I_op, I_data1, I_data2, I_flush,
    output O_ready, O_valid, O_data
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up applied on the edge that enters DONE.
module alu_muldiv #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic         I_clk,
  input  logic         I_rst,
  alu_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            accept, is_div, sa, sb, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  assign accept = (state_q == IDLE) && bus.I_start && !bus.I_flush;
  assign is_div = bus.I_op[2];
  assign sa = bus.I_data1[XLEN-1] &
              (is_div ? ~bus.I_op[0] : (bus.I_op[1:0] == 2'b01 || bus.I_op[1:0] == 2'b10));
  assign sb = bus.I_data2[XLEN-1] &
              (is_div ? ~bus.I_op[0] : (bus.I_op[1:0] == 2'b01));
  assign mag_a = sa ? -bus.I_data1 : bus.I_data1;
  assign mag_b = sb ? -bus.I_data2 : bus.I_data2;
  assign div0  = is_div && (bus.I_data2 == '0);
  assign ovf   = is_div && !bus.I_op[0] && (bus.I_data1 == MIN_NEG) && (bus.I_data2 == '1);
  assign fast_res = div0 ? (bus.I_op[1] ? bus.I_data1 : '1)
                         : (bus.I_op[1] ? '0 : bus.I_data1);

  // Multiply step: low half holds the remaining multiplier bits, high half accumulates.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: remainder stays below the divisor, so bit XLEN of the difference is its sign.
  logic [XLEN:0]     r_shift, r_diff;
  logic              q_bit;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   rem_next;
  assign r_shift  = {rem_q, acc_q[XLEN-1]};
  assign r_diff   = r_shift - {1'b0, b_q};
  assign q_bit    = ~r_diff[XLEN];
  assign div_next = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
  assign rem_next = q_bit ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0];

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
  assign prod_fix = neg_q ? -mul_next : mul_next;
  assign quo_fix  = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fix  = neg_q ? -rem_next : rem_next;
  assign fin_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                            : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                    : prod_fix[2*XLEN-1:XLEN]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.I_op;
          b_d   = mag_b;
          cnt_d = '0;
          rem_d = '0;
          acc_d = {{XLEN{1'b0}}, mag_a};
          neg_d = (bus.I_op[2] && bus.I_op[1]) ? sa : (sa ^ sb);
          if (div0 || ovf) begin
            res_d   = fast_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.I_flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = op_q[2] ? div_next : mul_next;
          rem_d = rem_next;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            res_d   = fin_res;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign bus.O_ready = (state_q == IDLE);
  assign bus.O_valid = (state_q == DONE);
  assign bus.O_data  = res_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at XLEN=32.
module tb_alu_muldiv;
  localparam int XLEN = 32;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  alu_muldiv_if #(.XLEN(XLEN)) bus();
  alu_muldiv #(.XLEN(XLEN)) dut (.I_clk(clk), .I_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.I_start = 1'b1; bus.I_op = op; bus.I_data1 = a; bus.I_data2 = b;
    @(posedge clk);
    @(negedge clk);
    bus.I_start = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int k, output int rdy_hi);
    k = 0; rdy_hi = 0;
    while (bus.O_valid !== 1'b1 && k < bound) begin
      if (bus.O_ready === 1'b1) rdy_hi++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k, r;
    issue(op, a, b);
    wait_valid(lat + 8, k, r);
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_data"}, bus.O_data, exp);
    chk({tag, "_rdy"}, r, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, bus.O_valid}, 0);
  endtask

  initial begin
    int v, vk, k;
    logic [31:0] vd;
    bus.I_start = 1'b0; bus.I_flush = 1'b0; bus.I_op = '0;
    bus.I_data1 = '0; bus.I_data2 = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.O_ready}, 1);
    chk("rst_valid", {31'b0, bus.O_valid}, 0);
    chk("rst_data", bus.O_data, 0);
    rst = 1'b0;

    run_op("mul_7_m3", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32);
    run_op("mulh_min", MULH, 32'h80000000, 32'h80000000, 32'h40000000, 32);
    run_op("mulhu_ff", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
    run_op("mulhsu_ff", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
    run_op("mul_ff", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    run_op("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32);
    run_op("rem_m7_2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32);
    run_op("divu_big", DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32);
    run_op("remu_big", REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32);
    run_op("rem_7_m2", REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32);

    run_op("div_by0", DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    run_op("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run_op("remu_by0", REMU, 32'd5, 32'd0, 32'h00000005, 0);

    // Flush mid-calculation: result discarded, previous O_data kept.
    issue(DIV, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    bus.I_flush = 1'b1;
    @(negedge clk);
    bus.I_flush = 1'b0;
    chk("flush_ready", {31'b0, bus.O_ready}, 1);
    chk("flush_valid", {31'b0, bus.O_valid}, 0);
    chk("flush_data", bus.O_data, 32'h5);
    v = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.O_valid === 1'b1) v++;
    end
    chk("flush_novalid", v, 0);

    // Start pulses while busy carry different operands and must be ignored.
    issue(DIV, 32'd100, 32'd3);
    v = 0; vk = -1; vd = '0;
    for (int c = 1; c <= 40; c++) begin
      bus.I_start = (c == 5 || c == 20);
      bus.I_op = MUL; bus.I_data1 = 32'd9; bus.I_data2 = 32'd9;
      @(negedge clk);
      bus.I_start = 1'b0;
      if (bus.O_valid === 1'b1) begin v++; vk = c; vd = bus.O_data; end
    end
    chk("busy_count", v, 1);
    chk("busy_lat", vk, 32);
    chk("busy_data", vd, 32'd33);

    // Start together with flush in IDLE is not accepted.
    @(negedge clk);
    bus.I_start = 1'b1; bus.I_flush = 1'b1; bus.I_op = DIVU;
    bus.I_data1 = 32'd100; bus.I_data2 = 32'd3;
    @(negedge clk);
    bus.I_start = 1'b0; bus.I_flush = 1'b0;
    chk("sflush_ready", {31'b0, bus.O_ready}, 1);
    v = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.O_valid === 1'b1) v++;
    end
    chk("sflush_novalid", v, 0);

    // Reset in the middle of a MULHU.
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'b0, bus.O_ready}, 1);
    chk("midrst_valid", {31'b0, bus.O_valid}, 0);
    chk("midrst_data", bus.O_data, 0);
    run_op("mul_3_4", MUL, 32'd3, 32'd4, 32'h0000000C, 32);

    // Back-to-back: start held high, second accept XLEN+2 edges after the first.
    @(negedge clk);
    bus.I_start = 1'b1; bus.I_op = MUL; bus.I_data1 = 32'd5; bus.I_data2 = 32'd6;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    while (bus.O_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_first_lat", k, 32);
    chk("b2b_first_data", bus.O_data, 32'd30);
    bus.I_op = DIVU; bus.I_data1 = 32'd100; bus.I_data2 = 32'd7;
    do begin
      @(negedge clk);
      k++;
    end while (bus.O_valid !== 1'b1 && k < 100);
    bus.I_start = 1'b0;
    chk("b2b_second_lat", k, 66);
    chk("b2b_second_data", bus.O_data, 32'd14);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
